// File: rtl/superfsm_spec_if.sv
// Vending-machine bus: product select and coin inputs, dispense strobe and change outputs.
interface superfsm_spec_if;
    logic [3:0] P;
    logic [2:0] D;
    logic [3:0] OUT;
    logic [2:0] VF;

    modport master (output P, D, input OUT, VF);
    modport slave  (input P, D, output OUT, VF);
endinterface

// File: rtl/superfsm_spec.sv
// Vending FSM: rising-edge product select and coin accumulation, one-clock registered dispense with change.
// OUT/VF appear right after the clock edge that samples the completing coin; no backpressure.
module superfsm_spec (
    input  logic            clock,
    input  logic            reset,
    superfsm_spec_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PAY, DISPENSE} state_t;

    state_t     state_q, state_d;
    logic [3:0] prev_p_q;
    logic [2:0] prev_d_q;
    logic [1:0] prod_q, prod_d;
    logic [3:0] price_q, price_d;
    logic [3:0] credit_q, credit_d;
    logic [3:0] out_q, out_d;
    logic [2:0] vf_q, vf_d;

    logic [3:0] p_edge;
    logic [2:0] d_edge;
    logic [3:0] coin_sum;
    logic [4:0] total;
    logic       p_onehot;

    assign p_edge   = bus.P & ~prev_p_q;
    assign d_edge   = bus.D & ~prev_d_q;
    assign coin_sum = {3'b000, d_edge[0]}
                    + (d_edge[1] ? 4'd2 : 4'd0)
                    + (d_edge[2] ? 4'd5 : 4'd0);
    // Credit never exceeds price-1, so a 5-bit sum cannot overflow.
    assign total    = {1'b0, credit_q} + {1'b0, coin_sum};
    assign p_onehot = (p_edge != 4'b0000) && ((p_edge & (p_edge - 4'd1)) == 4'b0000);

    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        price_d  = price_q;
        credit_d = credit_q;
        out_d    = 4'b0000;
        vf_d     = 3'b000;
        case (state_q)
            IDLE: begin
                if (p_onehot) begin
                    credit_d = 4'd0;
                    state_d  = PAY;
                    case (p_edge)
                        4'b0001: begin prod_d = 2'd0; price_d = 4'd1;  end
                        4'b0010: begin prod_d = 2'd1; price_d = 4'd5;  end
                        4'b0100: begin prod_d = 2'd2; price_d = 4'd10; end
                        default: begin prod_d = 2'd3; price_d = 4'd11; end
                    endcase
                end
            end
            PAY: begin
                if (total >= {1'b0, price_q}) begin
                    state_d = DISPENSE;
                    out_d   = 4'b0001 << prod_q;
                    vf_d    = 3'(total - {1'b0, price_q});
                end else begin
                    credit_d = total[3:0];
                end
            end
            DISPENSE: begin
                state_d  = IDLE;
                credit_d = 4'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            prev_p_q <= 4'b0000;
            prev_d_q <= 3'b000;
            prod_q   <= 2'd0;
            price_q  <= 4'd0;
            credit_q <= 4'd0;
            out_q    <= 4'b0000;
            vf_q     <= 3'b000;
        end else begin
            state_q  <= state_d;
            prev_p_q <= bus.P;
            prev_d_q <= bus.D;
            prod_q   <= prod_d;
            price_q  <= price_d;
            credit_q <= credit_d;
            out_q    <= out_d;
            vf_q     <= vf_d;
        end
    end

    assign bus.OUT = out_q;
    assign bus.VF  = vf_q;

endmodule

// File: tb/tb_superfsm_spec.sv
// Self-checking bench for superfsm_spec: vector table plus hand sequences, scoreboard of expected OUT/VF.
module tb_superfsm_spec;

    logic clock = 1'b0;
    logic reset;

    superfsm_spec_if bus ();

    superfsm_spec dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] p;
        logic [2:0] d;
        logic [3:0] eo;
        logic [2:0] ev;
    } vec_t;

    vec_t       tbl[$];
    logic [6:0] sb[$];
    int         total = 0;
    int         bad   = 0;

    task automatic add(input logic [3:0] p, input logic [2:0] d,
                       input logic [3:0] eo, input logic [2:0] ev);
        vec_t v;
        v.p = p; v.d = d; v.eo = eo; v.ev = ev;
        tbl.push_back(v);
    endtask

    task automatic check_out(input string nm);
        logic [6:0] e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, OUT=%b VF=%b", nm, bus.OUT, bus.VF);
        end else begin
            e = sb.pop_front();
            if ({bus.OUT, bus.VF} !== e) begin
                bad++;
                $display("FAIL %s: got OUT=%b VF=%b, expected OUT=%b VF=%b",
                         nm, bus.OUT, bus.VF, e[6:3], e[2:0]);
            end
        end
    endtask

    task automatic step(input logic [3:0] p, input logic [2:0] d,
                        input logic [3:0] eo, input logic [2:0] ev, input string nm);
        bus.P = p;
        bus.D = d;
        sb.push_back({eo, ev});
        @(posedge clock);
        #1;
        check_out(nm);
    endtask

    task automatic check_now(input logic [3:0] eo, input logic [2:0] ev, input string nm);
        sb.push_back({eo, ev});
        check_out(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.P = 4'b0000;
        bus.D = 3'b000;

        // price 1 / exact; price 5 with 5-coin; price 11 via 5+1+5
        add(4'b0001, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b001, 4'b0001, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        add(4'b0010, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0010, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        add(4'b1000, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0000, 3'd0);
        add(4'b0000, 3'b001, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b1000, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        // price 10 exact with two 5-coins
        add(4'b0100, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0000, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0100, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        // price 10 paid 12, change 2
        add(4'b0100, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0000, 3'd0);
        add(4'b0000, 3'b010, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0100, 3'd2);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        // coins in IDLE and non-one-hot P are ignored
        add(4'b0000, 3'b111, 4'b0000, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        add(4'b0011, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b001, 4'b0000, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        // all coins at once: 8 - 1 = 7; inputs during dispense ignored, edges still tracked
        add(4'b0001, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b111, 4'b0001, 3'd7);
        add(4'b0010, 3'b000, 4'b0000, 3'd0);
        add(4'b0010, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0000, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        // credit 10 plus all coins at price 11: change 7
        add(4'b1000, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0000, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0000, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b111, 4'b1000, 3'd7);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        // P edge during PAY cannot change the product
        add(4'b0100, 3'b000, 4'b0000, 3'd0);
        add(4'b0001, 3'b001, 4'b0000, 3'd0);
        add(4'b0000, 3'b100, 4'b0000, 3'd0);
        add(4'b0000, 3'b010, 4'b0000, 3'd0);
        add(4'b0000, 3'b001, 4'b0000, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);
        add(4'b0000, 3'b001, 4'b0100, 3'd0);
        add(4'b0000, 3'b000, 4'b0000, 3'd0);

        #12;
        check_now(4'b0000, 3'd0, "reset_state");
        #4;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].p, tbl[i].d, tbl[i].eo, tbl[i].ev, $sformatf("vec%0d", i));

        // Held 5-coin in PAY counts once (would reach 15 and dispense if counted thrice)
        step(4'b1000, 3'b000, 4'b0000, 3'd0, "hold_sel");
        step(4'b0000, 3'b100, 4'b0000, 3'd0, "hold_c1");
        step(4'b0000, 3'b100, 4'b0000, 3'd0, "hold_c2");
        step(4'b0000, 3'b100, 4'b0000, 3'd0, "hold_c3");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "hold_gap");
        step(4'b0000, 3'b100, 4'b0000, 3'd0, "hold_c10");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "hold_gap2");
        step(4'b0000, 3'b001, 4'b1000, 3'd0, "hold_disp");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "hold_idle");

        // Completing coin held: one-clock pulse, no repeat
        step(4'b0100, 3'b000, 4'b0000, 3'd0, "pw_sel");
        step(4'b0000, 3'b100, 4'b0000, 3'd0, "pw_c5");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "pw_gap");
        step(4'b0000, 3'b100, 4'b0100, 3'd0, "pw_disp");
        step(4'b0000, 3'b100, 4'b0000, 3'd0, "pw_end");
        step(4'b0000, 3'b100, 4'b0000, 3'd0, "pw_idle");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "pw_rel");

        // Reset during PAY with credit 5 abandons the transaction
        step(4'b0100, 3'b000, 4'b0000, 3'd0, "rp_sel");
        step(4'b0000, 3'b100, 4'b0000, 3'd0, "rp_c5");
        bus.D = 3'b000;
        reset = 1'b0;
        #1;
        check_now(4'b0000, 3'd0, "rp_async");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "rp_held");
        reset = 1'b1;
        step(4'b0010, 3'b000, 4'b0000, 3'd0, "rp_sel2");
        step(4'b0000, 3'b010, 4'b0000, 3'd0, "rp_c2");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "rp_gap");
        step(4'b0000, 3'b001, 4'b0000, 3'd0, "rp_c3");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "rp_gap2");
        step(4'b0000, 3'b100, 4'b0010, 3'd3, "rp_disp");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "rp_idle");

        // Reset during DISPENSE clears outputs at once; input high at release is an edge
        step(4'b0001, 3'b000, 4'b0000, 3'd0, "rd_sel");
        step(4'b0000, 3'b001, 4'b0001, 3'd0, "rd_disp");
        bus.P = 4'b0001;
        reset = 1'b0;
        #1;
        check_now(4'b0000, 3'd0, "rd_async");
        step(4'b0001, 3'b000, 4'b0000, 3'd0, "rd_in_reset");
        reset = 1'b1;
        step(4'b0001, 3'b000, 4'b0000, 3'd0, "rd_first_edge");
        step(4'b0001, 3'b001, 4'b0001, 3'd0, "rd_disp2");
        step(4'b0000, 3'b000, 4'b0000, 3'd0, "rd_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
